// File: rtl/fractal_sync_pkg.sv
// Shared types and width helpers for the fractal_sync counting barrier blocks.
package fractal_sync_pkg;

  // Low id bits that do not take part in selecting a local entry.
  localparam int unsigned FS_ID_IGNORED_LSBS = 1;

  // Per-port response registered one cycle after the request.
  typedef struct packed {
    logic ack;
    logic last;
    logic err;
  } fractal_sync_cnt_rsp_t;

  // Width of the local entry index carried inside a barrier id.
  function automatic int unsigned fs_local_idx_width(input int unsigned id_width);
    return id_width - FS_ID_IGNORED_LSBS;
  endfunction

  // Width of an arrival count: fits every port arriving at once.
  function automatic int unsigned fs_arrival_width(input int unsigned n_ports);
    return $clog2(n_ports + 1);
  endfunction

  // Width of count + same-cycle arrivals, wide enough that it never wraps.
  function automatic int unsigned fs_sum_width(input int unsigned cnt_width,
                                               input int unsigned n_ports);
    return cnt_width + $clog2(n_ports + 1);
  endfunction

endpackage

// File: rtl/fractal_sync_arrival_cnt.sv
// One barrier entry: arrival counter, programmable target and config accept.
module fractal_sync_arrival_cnt
  import fractal_sync_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 2,
  parameter int unsigned N_PORTS        = 2,
  parameter int unsigned DEFAULT_TARGET = 2,
  parameter int unsigned K_W            = fs_arrival_width(N_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [K_W-1:0]       k_i,
  input  logic [N_PORTS-1:0]   first_oh_i,
  input  logic                 cfg_we_i,
  input  logic [CNT_WIDTH-1:0] cfg_target_i,
  output logic                 wake_o,
  output logic                 busy_o,
  output logic                 en_o,
  output logic                 overflow_o,
  output logic [N_PORTS-1:0]   last_oh_o,
  output logic                 cfg_rej_o
);

  localparam int unsigned SUM_W = fs_sum_width(CNT_WIDTH, N_PORTS);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] target_q;
  logic                 wake_q;
  logic [SUM_W-1:0]     sum;
  logic                 arrive;
  logic                 complete;
  logic                 cfg_ok;

  // Merge this cycle's arrivals into the count and classify the outcome.
  always_comb begin
    sum        = SUM_W'(cnt_q) + SUM_W'(k_i);
    arrive     = (k_i != '0);
    complete   = arrive && (sum == SUM_W'(target_q));
    overflow_o = arrive && (sum > SUM_W'(target_q));
    last_oh_o  = complete ? first_oh_i : '0;
    cfg_ok     = cfg_we_i && (cnt_q == '0) && !arrive;
    cfg_rej_o  = cfg_we_i && !cfg_ok;
  end

  // Count, target and wake pulse; completion and overflow both restart the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      target_q <= CNT_WIDTH'(DEFAULT_TARGET);
      wake_q   <= 1'b0;
    end else begin
      wake_q <= complete;
      if (complete || overflow_o) begin
        cnt_q <= '0;
      end else if (arrive) begin
        cnt_q <= CNT_WIDTH'(sum);
      end
      if (cfg_ok) begin
        target_q <= cfg_target_i;
      end
    end
  end

  assign wake_o = wake_q;
  assign busy_o = (cnt_q != '0);
  assign en_o   = (target_q != '0);

endmodule

// File: rtl/fractal_sync_cnt_local_rf.sv
// Local counting barrier register file: decodes port ids, merges same-cycle
// arrivals per entry and registers the per-port responses.
module fractal_sync_cnt_local_rf
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N_REGS         = 4,
  parameter int unsigned ID_WIDTH       = 3,
  parameter int unsigned N_PORTS        = 2,
  parameter int unsigned CNT_WIDTH      = 2,
  parameter int unsigned DEFAULT_TARGET = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [N_PORTS-1:0]                req_i,
  input  logic [N_PORTS-1:0][ID_WIDTH-1:0]  id_i,
  output logic [N_PORTS-1:0]                ack_o,
  output logic [N_PORTS-1:0]                last_o,
  output logic [N_PORTS-1:0]                err_o,
  output logic [N_REGS-1:0]                 wake_o,
  output logic [N_REGS-1:0]                 busy_o,
  input  logic                              cfg_we_i,
  input  logic [ID_WIDTH-2:0]               cfg_idx_i,
  input  logic [CNT_WIDTH-1:0]              cfg_target_i,
  output logic                              cfg_err_o
);

  localparam int unsigned IDX_W = fs_local_idx_width(ID_WIDTH);
  localparam int unsigned K_W   = fs_arrival_width(N_PORTS);

  logic [N_PORTS-1:0][IDX_W-1:0]  idx;
  logic [N_REGS-1:0][N_PORTS-1:0] hit;
  logic [N_REGS-1:0][N_PORTS-1:0] first_oh;
  logic [N_REGS-1:0][N_PORTS-1:0] last_oh;
  logic [N_REGS-1:0][K_W-1:0]     k;
  logic [N_REGS-1:0]              en;
  logic [N_REGS-1:0]              ovf;
  logic [N_REGS-1:0]              cfg_sel;
  logic [N_REGS-1:0]              cfg_rej;

  fractal_sync_cnt_rsp_t [N_PORTS-1:0] rsp_d;
  fractal_sync_cnt_rsp_t [N_PORTS-1:0] rsp_q;
  logic                                cfg_err_d;
  logic                                cfg_err_q;

  // Index decode, per-entry arrival popcount and lowest-port priority select.
  // Requests to a disabled entry are not arrivals; they only produce an error.
  always_comb begin
    idx      = '0;
    hit      = '0;
    first_oh = '0;
    k        = '0;
    cfg_sel  = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      idx[p] = id_i[p][ID_WIDTH-1:FS_ID_IGNORED_LSBS];
    end
    for (int unsigned i = 0; i < N_REGS; i++) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (req_i[p] && (32'(idx[p]) == i) && en[i]) begin
          hit[i][p] = 1'b1;
          k[i]      = k[i] + K_W'(1);
          if (first_oh[i] == '0) begin
            first_oh[i][p] = 1'b1;
          end
        end
      end
      cfg_sel[i] = cfg_we_i && (32'(cfg_idx_i) == i);
    end
  end

  for (genvar gi = 0; gi < N_REGS; gi++) begin : g_entry
    fractal_sync_arrival_cnt #(
      .CNT_WIDTH      (CNT_WIDTH),
      .N_PORTS        (N_PORTS),
      .DEFAULT_TARGET (DEFAULT_TARGET),
      .K_W            (K_W)
    ) u_entry (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .k_i          (k[gi]),
      .first_oh_i   (first_oh[gi]),
      .cfg_we_i     (cfg_sel[gi]),
      .cfg_target_i (cfg_target_i),
      .wake_o       (wake_o[gi]),
      .busy_o       (busy_o[gi]),
      .en_o         (en[gi]),
      .overflow_o   (ovf[gi]),
      .last_oh_o    (last_oh[gi]),
      .cfg_rej_o    (cfg_rej[gi])
    );
  end

  // Build next-cycle responses: a request is an error unless it landed on an
  // enabled entry that did not overflow.
  always_comb begin
    rsp_d     = '0;
    cfg_err_d = cfg_we_i && (32'(cfg_idx_i) >= N_REGS);
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      rsp_d[p].ack = req_i[p];
      rsp_d[p].err = req_i[p];
    end
    for (int unsigned i = 0; i < N_REGS; i++) begin
      cfg_err_d = cfg_err_d | cfg_rej[i];
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (hit[i][p]) begin
          rsp_d[p].err  = ovf[i];
          rsp_d[p].last = last_oh[i][p];
        end
      end
    end
  end

  // Response registers: every response appears exactly one cycle after its request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      rsp_q     <= rsp_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Unpack the registered response structs onto the port vectors.
  always_comb begin
    ack_o  = '0;
    last_o = '0;
    err_o  = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      ack_o[p]  = rsp_q[p].ack;
      last_o[p] = rsp_q[p].last;
      err_o[p]  = rsp_q[p].err;
    end
  end

  assign cfg_err_o = cfg_err_q;

endmodule
